// File: rtl/rd_data_collector_pkg.sv
// Shared constants and types for the DFI read-data collector.
// Covers burst length, read tag encoding and serializer states.
package rd_data_collector_pkg;

  localparam int unsigned BURST_BEATS = 4;

  localparam logic TAG_HOST     = 1'b0;
  localparam logic TAG_PERIODIC = 1'b1;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } ser_state_e;

endpackage

// File: rtl/rd_data_collector_if.sv
// DFI read-return and host read-back stream signals of the read-data collector.
interface rd_data_collector_if
  import rd_data_collector_pkg::*;
#(
  parameter int unsigned DQ_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH = 64
) ();

  logic                            dfi_rddata_en;
  logic                            dfi_rddata_en_odd;
  logic                            dfi_rddata_valid;
  logic [BURST_BEATS*DQ_WIDTH-1:0] dfi_rddata;
  logic [OUT_WIDTH-1:0]            rdback_data;
  logic                            rdback_valid;
  logic                            rdback_ready;
  logic                            rdback_last;

  modport master (
    output dfi_rddata_en,
    output dfi_rddata_en_odd,
    output dfi_rddata_valid,
    output dfi_rddata,
    output rdback_ready,
    input  rdback_data,
    input  rdback_valid,
    input  rdback_last
  );

  modport slave (
    input  dfi_rddata_en,
    input  dfi_rddata_en_odd,
    input  dfi_rddata_valid,
    input  dfi_rddata,
    input  rdback_ready,
    output rdback_data,
    output rdback_valid,
    output rdback_last
  );

endinterface

// File: rtl/rd_data_collector_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty/occupancy outputs.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [Width-1:0]       wdata_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (AddrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rd_data_collector.sv
// DFI read-return collector: matches in-order read tags against PHY bursts,
// serializes host bursts to the read-back stream and forwards periodic reads.
module rd_data_collector
  import rd_data_collector_pkg::*;
#(
  parameter int unsigned DQ_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH = 64,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  rd_data_collector_if.slave              rd,
  input  logic                            clr_err,
  output logic                            pr_rd_valid,
  output logic [BURST_BEATS*DQ_WIDTH-1:0] pr_rd_data,
  output logic [$clog2(DEPTH):0]          rd_pending,
  output logic                            rd_credit_ok,
  output logic                            err_overflow,
  output logic                            err_unexpected
);

  localparam int unsigned BurstW = BURST_BEATS * DQ_WIDTH;
  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned BeatW  = $clog2(BURST_BEATS);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_BEATS - 1);

  logic              tag_head, tag_full, tag_empty;
  logic [CntW-1:0]   tag_count;
  logic [BurstW-1:0] burst_head;
  logic              burst_full, burst_empty;
  logic [CntW-1:0]   burst_count;

  logic tag_pop, host_evt, prd_evt, unexp_evt, ovf_evt, burst_pop;

  ser_state_e        state_q, state_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              pr_valid_q, pr_valid_d;
  logic [BurstW-1:0] pr_data_q, pr_data_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unexp_q, err_unexp_d;
  logic [CntW:0]     occupancy;

  assign tag_pop   = rd.dfi_rddata_valid && !tag_empty;
  assign host_evt  = tag_pop && (tag_head == TAG_HOST);
  assign prd_evt   = tag_pop && (tag_head == TAG_PERIODIC);
  assign unexp_evt = rd.dfi_rddata_valid && tag_empty;
  assign ovf_evt   = (rd.dfi_rddata_en && tag_full && !tag_pop) ||
                     (host_evt && burst_full && !burst_pop);

  sync_fifo #(
    .Width (1),
    .Depth (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd.dfi_rddata_en),
    .pop_i   (tag_pop),
    .wdata_i (rd.dfi_rddata_en_odd),
    .rdata_o (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  sync_fifo #(
    .Width (BurstW),
    .Depth (DEPTH)
  ) u_burst_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (host_evt),
    .pop_i   (burst_pop),
    .wdata_i (rd.dfi_rddata),
    .rdata_o (burst_head),
    .full_o  (burst_full),
    .empty_o (burst_empty),
    .count_o (burst_count)
  );

  // The FIFO head is the burst being sent; it is only popped after its last beat.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    burst_pop = 1'b0;
    case (state_q)
      StIdle: begin
        if (!burst_empty) begin
          state_d = StSend;
          beat_d  = '0;
        end
      end
      StSend: begin
        if (rd.rdback_ready) begin
          if (beat_q == LastBeat) begin
            burst_pop = 1'b1;
            beat_d    = '0;
            if ((burst_count <= CntW'(1)) && !host_evt) state_d = StIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pr_valid_d  = prd_evt;
    pr_data_d   = prd_evt ? rd.dfi_rddata : pr_data_q;
    err_ovf_d   = (err_ovf_q && !clr_err) || ovf_evt;
    err_unexp_d = (err_unexp_q && !clr_err) || unexp_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      pr_valid_q  <= 1'b0;
      pr_data_q   <= '0;
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pr_valid_q  <= pr_valid_d;
      pr_data_q   <= pr_data_d;
      err_ovf_q   <= err_ovf_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign rd.rdback_valid = (state_q == StSend);
  assign rd.rdback_last  = (state_q == StSend) && (beat_q == LastBeat);
  assign rd.rdback_data  = (state_q == StSend) ?
                           burst_head[32'(beat_q)*OUT_WIDTH +: OUT_WIDTH] : '0;

  assign occupancy = {1'b0, tag_count} + {1'b0, burst_count} +
                     {{CntW{1'b0}}, (state_q == StSend)};

  assign pr_rd_valid    = pr_valid_q;
  assign pr_rd_data     = pr_data_q;
  assign rd_pending     = tag_count;
  assign rd_credit_ok   = (occupancy < (CntW+1)'(DEPTH));
  assign err_overflow   = err_ovf_q;
  assign err_unexpected = err_unexp_q;

endmodule

// File: tb/tb_rd_data_collector.sv
// Scoreboard bench for rd_data_collector: expected host words and periodic
// bursts are queued at stimulus time and retired as the DUT emits them.
module tb_rd_data_collector;
  import rd_data_collector_pkg::*;

  localparam int unsigned DQ    = 64;
  localparam int unsigned DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr_err = 1'b0;
  logic         pr_rd_valid;
  logic [255:0] pr_rd_data;
  logic [4:0]   rd_pending;
  logic         rd_credit_ok, err_overflow, err_unexpected;

  rd_data_collector_if #(.DQ_WIDTH(DQ), .OUT_WIDTH(DQ)) bus ();

  rd_data_collector #(
    .DQ_WIDTH  (DQ),
    .OUT_WIDTH (DQ),
    .DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rd             (bus),
    .clr_err        (clr_err),
    .pr_rd_valid    (pr_rd_valid),
    .pr_rd_data     (pr_rd_data),
    .rd_pending     (rd_pending),
    .rd_credit_ok   (rd_credit_ok),
    .err_overflow   (err_overflow),
    .err_unexpected (err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } word_t;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           hs_count = 0;
  int           last_count = 0;
  word_t        exp_q[$];
  logic [255:0] pr_q[$];
  bit           tag_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Retires scoreboard entries and checks hold-while-stalled on the host stream.
  logic        stall_prev = 1'b0;
  logic [63:0] data_prev = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        total++;
        if (!bus.rdback_valid || bus.rdback_data !== data_prev) begin
          bad++;
          $display("FAIL hold_stable valid=%0b data=%h want valid=1 data=%h",
                   bus.rdback_valid, bus.rdback_data, data_prev);
        end
      end
      if (bus.rdback_valid && bus.rdback_ready) begin
        word_t w;
        hs_count++;
        if (bus.rdback_last) last_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word got=%h last=%0b want=none",
                   bus.rdback_data, bus.rdback_last);
        end else begin
          w = exp_q.pop_front();
          if ({bus.rdback_data, bus.rdback_last} !== {w.data, w.last}) begin
            bad++;
            $display("FAIL host_word got=%h last=%0b want=%h last=%0b",
                     bus.rdback_data, bus.rdback_last, w.data, w.last);
          end
        end
      end
      stall_prev = bus.rdback_valid && !bus.rdback_ready;
      data_prev  = bus.rdback_data;
      if (pr_rd_valid) begin
        total++;
        if (pr_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pr got=%h want=none", pr_rd_data);
        end else begin
          logic [255:0] p;
          p = pr_q.pop_front();
          if (pr_rd_data !== p) begin
            bad++;
            $display("FAIL pr_data got=%h want=%h", pr_rd_data, p);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.rdback_ready = 1'b1;
    tick();
    tick();
    exp_q.delete();
    pr_q.delete();
    tag_q.delete();
    rst = 1'b0;
  endtask

  task automatic issue(input bit odd);
    bus.dfi_rddata_en     = 1'b1;
    bus.dfi_rddata_en_odd = odd;
    if (tag_q.size() < DEPTH) tag_q.push_back(odd);
    tick();
    bus.dfi_rddata_en     = 1'b0;
    bus.dfi_rddata_en_odd = 1'b0;
  endtask

  task automatic send_burst(input logic [255:0] d);
    bus.dfi_rddata_valid = 1'b1;
    bus.dfi_rddata       = d;
    if (tag_q.size() != 0) begin
      if (tag_q.pop_front()) begin
        pr_q.push_back(d);
      end else begin
        for (int b = 0; b < 4; b++) exp_q.push_back({d[b*64 +: 64], (b == 3)});
      end
    end
    tick();
    bus.dfi_rddata_valid = 1'b0;
  endtask

  function automatic logic [255:0] rand_burst();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if ({bus.rdback_valid, bus.rdback_last, pr_rd_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_valids got=%b want=000",
               {bus.rdback_valid, bus.rdback_last, pr_rd_valid});
    end
    total++;
    if (bus.rdback_data !== 64'd0 || pr_rd_data !== 256'd0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h want=0", bus.rdback_data, pr_rd_data);
    end
    total++;
    if (rd_pending !== 5'd0 || rd_credit_ok !== 1'b1) begin
      bad++;
      $display("FAIL reset_counts pending=%0d credit=%0b want 0/1", rd_pending, rd_credit_ok);
    end
    total++;
    if ({err_overflow, err_unexpected} !== 2'b00) begin
      bad++;
      $display("FAIL reset_errs got=%b want=00", {err_overflow, err_unexpected});
    end
  endtask

  task automatic test_single_host();
    logic [255:0] d;
    d = {64'h4444444444444444, 64'h3333333333333333,
         64'h2222222222222222, 64'h1111111111111111};
    issue(1'b0);
    @(negedge clk);
    total++;
    if (rd_pending !== 5'd1) begin
      bad++;
      $display("FAIL single_pending_1 got=%0d want=1", rd_pending);
    end
    repeat (9) tick();
    send_burst(d);
    @(negedge clk);
    total++;
    if (bus.rdback_valid !== 1'b0 || rd_pending !== 5'd0) begin
      bad++;
      $display("FAIL single_t1 valid=%0b pending=%0d want 0/0", bus.rdback_valid, rd_pending);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      total++;
      if (bus.rdback_valid !== 1'b1) begin
        bad++;
        $display("FAIL single_word_slot%0d valid=%0b want=1", i, bus.rdback_valid);
      end
    end
    tick();
    @(negedge clk);
    #1;
    total++;
    if (bus.rdback_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_end valid=%0b left=%0d want 0/0", bus.rdback_valid, exp_q.size());
    end
  endtask

  task automatic test_mixed();
    logic [255:0] a, b, c;
    int c0, h0;
    bit done;
    a = rand_burst();
    b = rand_burst();
    c = rand_burst();
    issue(1'b0);
    issue(1'b1);
    issue(1'b0);
    tick();
    h0 = hs_count;
    c0 = cyc;
    send_burst(a);
    send_burst(b);
    @(negedge clk);
    total++;
    if (pr_rd_valid !== 1'b1 || pr_rd_data !== b) begin
      bad++;
      $display("FAIL mixed_pr valid=%0b data=%h want 1/%h", pr_rd_valid, pr_rd_data, b);
    end
    send_burst(c);
    @(negedge clk);
    total++;
    if (pr_rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL mixed_pr_pulse valid=%0b want=0", pr_rd_valid);
    end
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      @(negedge clk);
      #1;
      if (hs_count >= h0 + 8) done = 1'b1;
    end
    total++;
    if (!done || (cyc - c0) != 9) begin
      bad++;
      $display("FAIL mixed_throughput done=%0b cycles=%0d want 1/9", done, cyc - c0);
    end
    total++;
    if ({err_overflow, err_unexpected} !== 2'b00 || exp_q.size() != 0 || pr_q.size() != 0) begin
      bad++;
      $display("FAIL mixed_end errs=%b left=%0d/%0d want 00/0/0",
               {err_overflow, err_unexpected}, exp_q.size(), pr_q.size());
    end
  endtask

  task automatic test_backpressure();
    int h0, l0;
    issue(1'b0);
    tick();
    h0 = hs_count;
    l0 = last_count;
    send_burst(rand_burst());
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      bus.rdback_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    bus.rdback_ready = 1'b1;
    tick();
    total++;
    if (exp_q.size() != 0 || hs_count - h0 != 4) begin
      bad++;
      $display("FAIL bp_words left=%0d taken=%0d want 0/4", exp_q.size(), hs_count - h0);
    end
    total++;
    if (last_count - l0 != 1) begin
      bad++;
      $display("FAIL bp_last count=%0d want=1", last_count - l0);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 15; i++) issue(1'b0);
    @(negedge clk);
    total++;
    if (rd_credit_ok !== 1'b1) begin
      bad++;
      $display("FAIL ovf_credit15 got=%0b want=1", rd_credit_ok);
    end
    issue(1'b0);
    @(negedge clk);
    total++;
    if (rd_pending !== 5'd16 || rd_credit_ok !== 1'b0 || err_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_16 pending=%0d credit=%0b err=%0b want 16/0/0",
               rd_pending, rd_credit_ok, err_overflow);
    end
    issue(1'b0);
    @(negedge clk);
    total++;
    if (rd_pending !== 5'd16 || err_overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_17 pending=%0d err=%0b want 16/1", rd_pending, err_overflow);
    end
    clr_err = 1'b1;
    issue(1'b0);
    clr_err = 1'b0;
    @(negedge clk);
    total++;
    if (err_overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_clr_race got=%0b want=1", err_overflow);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    total++;
    if (err_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr got=%0b want=0", err_overflow);
    end
    apply_reset();
  endtask

  task automatic test_unexpected();
    send_burst(rand_burst());
    @(negedge clk);
    total++;
    if (err_unexpected !== 1'b1 || err_overflow !== 1'b0) begin
      bad++;
      $display("FAIL unexp_flag got=%b want=10", {err_unexpected, err_overflow});
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.rdback_valid !== 1'b0 || pr_rd_valid !== 1'b0) begin
        bad++;
        $display("FAIL unexp_quiet%0d got=%b want=00", i, {bus.rdback_valid, pr_rd_valid});
      end
      tick();
      @(negedge clk);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    total++;
    if (err_unexpected !== 1'b0) begin
      bad++;
      $display("FAIL unexp_clr got=%0b want=0", err_unexpected);
    end
  endtask

  task automatic test_reset_send();
    int h0, h1;
    bit seen;
    issue(1'b0);
    tick();
    h0 = hs_count;
    send_burst(rand_burst());
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (hs_count == h0 + 2) seen = 1'b1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rst_send_two_words taken=%0d want=2", hs_count - h0);
    end
    tick();
    rst = 1'b1;
    bus.rdback_ready = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    bus.rdback_ready = 1'b1;
    h1 = hs_count;
    @(negedge clk);
    total++;
    if (bus.rdback_valid !== 1'b0 || rd_pending !== 5'd0 || rd_credit_ok !== 1'b1) begin
      bad++;
      $display("FAIL rst_send_after valid=%0b pending=%0d credit=%0b want 0/0/1",
               bus.rdback_valid, rd_pending, rd_credit_ok);
    end
    repeat (10) tick();
    total++;
    if (hs_count != h1) begin
      bad++;
      $display("FAIL rst_send_quiet words=%0d want=0", hs_count - h1);
    end
  endtask

  initial begin
    bus.dfi_rddata_en     = 1'b0;
    bus.dfi_rddata_en_odd = 1'b0;
    bus.dfi_rddata_valid  = 1'b0;
    bus.dfi_rddata        = '0;
    bus.rdback_ready      = 1'b1;
    test_reset();
    test_single_host();
    test_mixed();
    test_backpressure();
    test_overflow();
    test_unexpected();
    test_reset_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
